// File: rtl/uart_fifo_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_wrapper_if
// Brief    : Host FIFO port plus serial pins of one uart_fifo_wrapper.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fifo_wrapper_if #(
    parameter int N_BIT = 8
);
    logic             rx;
    logic             tx;
    logic             rx_rd_en;
    logic             tx_wr_en;
    logic [N_BIT-1:0] tx_wr_data;
    logic             rx_empty;
    logic             rx_full;
    logic             tx_full;
    logic             rx_parity_error;
    logic             rx_frame_error;
    logic [N_BIT-1:0] rx_rd_data;

    modport slave (
        input  rx, rx_rd_en, tx_wr_en, tx_wr_data,
        output tx, rx_empty, rx_full, tx_full,
               rx_parity_error, rx_frame_error, rx_rd_data
    );

    modport master (
        output rx, rx_rd_en, tx_wr_en, tx_wr_data,
        input  tx, rx_empty, rx_full, tx_full,
               rx_parity_error, rx_frame_error, rx_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_wrapper (+ uart_fifo_wrapper_fifo)
// Brief    : Full-duplex even-parity UART with 16-deep TX and RX FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_wrapper_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              wr_en,
    input  wire [WIDTH-1:0]  wr_data,
    input  wire              rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int c_DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is cleared so the fall-through head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (AW+1)'(c_DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = r_empty;
endmodule

module uart_fifo_wrapper #(
    parameter int N_BIT   = 8,
    parameter int FIFO_AW = 4,
    parameter int DIVISOR = 326
) (
    input wire                  clk,
    input wire                  rst,
    uart_fifo_wrapper_if.slave  bus
);
    localparam int c_TICK_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(DIVISOR - 1);
    localparam int c_BIT_W = (N_BIT > 1) ? $clog2(N_BIT) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(N_BIT - 1);
    localparam logic [3:0] c_MID_TICK  = 4'd7;
    localparam logic [3:0] c_LAST_TICK = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // ---------------- 16x oversample tick ----------------
    logic [c_TICK_W-1:0] r_div_cnt;
    logic                w_tick;

    assign w_tick = (r_div_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // ---------------- FIFOs ----------------
    logic             w_tx_pop;
    logic             w_tx_empty;
    logic [N_BIT-1:0] w_tx_head;
    logic             w_rx_push;
    logic [N_BIT-1:0] r_rx_shift;

    uart_fifo_wrapper_fifo #(.WIDTH(N_BIT), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.tx_wr_en),
        .wr_data (bus.tx_wr_data),
        .rd_en   (w_tx_pop),
        .rd_data (w_tx_head),
        .full    (bus.tx_full),
        .empty   (w_tx_empty)
    );

    uart_fifo_wrapper_fifo #(.WIDTH(N_BIT), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_rx_push),
        .wr_data (r_rx_shift),
        .rd_en   (bus.rx_rd_en),
        .rd_data (bus.rx_rd_data),
        .full    (bus.rx_full),
        .empty   (bus.rx_empty)
    );

    // ---------------- Transmitter ----------------
    uart_state_t      r_tx_state, w_tx_state_next;
    logic [N_BIT-1:0] r_tx_shift, w_tx_shift_next;
    logic [c_BIT_W-1:0] r_tx_bit, w_tx_bit_next;
    logic [3:0]       r_tx_tick, w_tx_tick_next;
    logic             r_tx, w_tx_next;
    logic             w_tx_bit_done;

    assign w_tx_bit_done = w_tick && (r_tx_tick == c_LAST_TICK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_tick  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_tick  <= w_tx_tick_next;
            r_tx       <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_shift_next = r_tx_shift;
        w_tx_bit_next   = r_tx_bit;
        w_tx_tick_next  = r_tx_tick;
        w_tx_pop        = 1'b0;
        if (r_tx_state != ST_IDLE && w_tick) begin
            w_tx_tick_next = r_tx_tick + 1'b1;
        end
        case (r_tx_state)
            ST_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_head;
                    w_tx_bit_next   = '0;
                    w_tx_tick_next  = '0;
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tx_bit_done) w_tx_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tx_bit_done) begin
                    if (r_tx_bit == c_LAST_BIT) w_tx_state_next = ST_PARITY;
                    else                        w_tx_bit_next   = r_tx_bit + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_tx_bit_done) w_tx_state_next = ST_STOP;
            end
            ST_STOP: begin
                // A queued byte chains straight into the next start bit.
                if (w_tx_bit_done) begin
                    if (!w_tx_empty) begin
                        w_tx_pop        = 1'b1;
                        w_tx_shift_next = w_tx_head;
                        w_tx_bit_next   = '0;
                        w_tx_state_next = ST_START;
                    end else begin
                        w_tx_state_next = ST_IDLE;
                    end
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
    end

    // Line level is registered from the next-state view to keep tx glitch-free.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_tx_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_tx_shift_next[w_tx_bit_next];
            ST_PARITY: w_tx_next = ^w_tx_shift_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign bus.tx = r_tx;

    // ---------------- Receiver ----------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Edge-triggered arming: a line stuck low after a bad stop bit is ignored.
    assign w_rx_fall = r_rx_prev && !r_rx_sync;

    uart_state_t        r_rx_state, w_rx_state_next;
    logic [N_BIT-1:0]   w_rx_shift_next;
    logic [c_BIT_W-1:0] r_rx_bit, w_rx_bit_next;
    logic [3:0]         r_rx_tick, w_rx_tick_next;
    logic               r_rx_par_bad, w_rx_par_bad_next;
    logic               r_parity_err, w_parity_err_next;
    logic               r_frame_err, w_frame_err_next;
    logic               w_rx_sample;

    assign w_rx_sample = w_tick && (r_rx_tick == c_LAST_TICK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= ST_IDLE;
            r_rx_shift   <= '0;
            r_rx_bit     <= '0;
            r_rx_tick    <= '0;
            r_rx_par_bad <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_rx_shift   <= w_rx_shift_next;
            r_rx_bit     <= w_rx_bit_next;
            r_rx_tick    <= w_rx_tick_next;
            r_rx_par_bad <= w_rx_par_bad_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    always_comb begin
        w_rx_state_next   = r_rx_state;
        w_rx_shift_next   = r_rx_shift;
        w_rx_bit_next     = r_rx_bit;
        w_rx_tick_next    = r_rx_tick;
        w_rx_par_bad_next = r_rx_par_bad;
        w_parity_err_next = r_parity_err;
        w_frame_err_next  = r_frame_err;
        w_rx_push         = 1'b0;
        if (r_rx_state != ST_IDLE && w_tick) begin
            w_rx_tick_next = r_rx_tick + 1'b1;
        end
        case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_tick_next  = '0;
                    w_rx_state_next = ST_START;
                end
            end
            ST_START: begin
                // Half a bit in: still low means a real start, and re-centres sampling.
                if (w_tick && r_rx_tick == c_MID_TICK) begin
                    if (r_rx_sync) begin
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_tick_next  = '0;
                        w_rx_bit_next   = '0;
                        w_rx_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_sample) begin
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[N_BIT-1:1]};
                    if (r_rx_bit == c_LAST_BIT) w_rx_state_next = ST_PARITY;
                    else                        w_rx_bit_next   = r_rx_bit + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_rx_sample) begin
                    w_rx_par_bad_next = (r_rx_sync != ^r_rx_shift);
                    w_rx_state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_rx_sample) begin
                    w_rx_push         = 1'b1;
                    w_parity_err_next = r_rx_par_bad;
                    w_frame_err_next  = !r_rx_sync;
                    w_rx_state_next   = ST_IDLE;
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    assign bus.rx_parity_error = r_parity_err;
    assign bus.rx_frame_error  = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_wrapper
// Brief    : Two cross-connected UART peers with a bench-driven line into peer B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_wrapper;
    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inj_en  = 1'b0;
    logic inj_val = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_fifo_wrapper_if #(.N_BIT(8)) if_a ();
    uart_fifo_wrapper_if #(.N_BIT(8)) if_b ();

    assign if_a.rx = if_b.tx;
    assign if_b.rx = inj_en ? inj_val : if_a.tx;

    uart_fifo_wrapper #(.N_BIT(8), .FIFO_AW(4), .DIVISOR(DIV)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    uart_fifo_wrapper #(.N_BIT(8), .FIFO_AW(4), .DIVISOR(DIV)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    logic [7:0] tab_a [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3,
                               8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] tab_b [16] = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h11, 8'h22, 8'h44, 8'h88,
                               8'h7E, 8'hE7, 8'h81, 8'h18, 8'h6D, 8'hB6, 8'h93, 8'h2C};
    logic       wave_a5 [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-driven frame into peer B, followed by one idle bit.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_v);
        inj_val = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            inj_val = d[i];
            repeat (BIT) @(negedge clk);
        end
        inj_val = (^d) ^ flip_par;
        repeat (BIT) @(negedge clk);
        inj_val = stop_v;
        repeat (BIT) @(negedge clk);
        inj_val = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop_b();
        @(negedge clk) if_b.rx_rd_en = 1'b1;
        @(negedge clk) if_b.rx_rd_en = 1'b0;
    endtask

    task automatic pop_a();
        @(negedge clk) if_a.rx_rd_en = 1'b1;
        @(negedge clk) if_a.rx_rd_en = 1'b0;
    endtask

    logic [7:0] held;
    int         lat;

    initial begin
        if_a.rx_rd_en = 1'b0;  if_b.rx_rd_en = 1'b0;
        if_a.tx_wr_en = 1'b1;  if_b.tx_wr_en = 1'b1;
        if_a.tx_wr_data = 8'hFF; if_b.tx_wr_data = 8'hFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if_a.tx_wr_en = 1'b0; if_b.tx_wr_en = 1'b0;

        // Reset state; writes during reset must be discarded.
        check("rst_tx",       if_a.tx, 1);
        check("rst_tx_full",  if_a.tx_full, 0);
        check("rst_rx_empty", if_b.rx_empty, 1);
        check("rst_rx_full",  if_b.rx_full, 0);
        check("rst_perr",     if_b.rx_parity_error, 0);
        check("rst_ferr",     if_b.rx_frame_error, 0);
        check("rst_rd_data",  if_b.rx_rd_data, 0);
        repeat (50) @(negedge clk);
        check("rst_no_tx_a",  if_a.tx, 1);
        check("rst_no_tx_b",  if_b.tx, 1);

        // Loopback burst: 16 bytes each way on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            if_a.tx_wr_en = 1'b1; if_a.tx_wr_data = tab_a[i];
            if_b.tx_wr_en = 1'b1; if_b.tx_wr_data = tab_b[i];
            @(negedge clk);
        end
        if_a.tx_wr_en = 1'b0; if_b.tx_wr_en = 1'b0;
        check("burst_tx_full", if_a.tx_full, 0);
        for (int i = 0; i < 20000; i++) begin
            if (if_a.rx_full && if_b.rx_full) break;
            @(negedge clk);
        end
        check("loop_a_full", if_a.rx_full, 1);
        check("loop_b_full", if_b.rx_full, 1);
        check("loop_errs",   {if_a.rx_parity_error, if_a.rx_frame_error,
                              if_b.rx_parity_error, if_b.rx_frame_error}, 0);

        // 17th frame into a full RX FIFO is dropped.
        inj_en = 1'b1;
        send_frame(8'hE7, 1'b0, 1'b1);
        check("ovr_full", if_b.rx_full, 1);

        // Paced reads: 16 bytes in order, then two reads of an empty FIFO.
        held = 8'h00;
        for (int i = 0; i < 18; i++) begin
            repeat (200) @(negedge clk);
            if (i < 16) begin
                check($sformatf("b_rd%0d", i), if_b.rx_rd_data, tab_a[i]);
            end else begin
                if (i == 16) held = if_b.rx_rd_data;
                check($sformatf("b_empty%0d", i), if_b.rx_empty, 1);
                check($sformatf("b_hold%0d", i),  if_b.rx_rd_data, held);
            end
            pop_b();
        end
        check("b_hold_end",  if_b.rx_rd_data, held);
        check("b_empty_end", if_b.rx_empty, 1);
        check("b_not_full",  if_b.rx_full, 0);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_rd%0d", i), if_a.rx_rd_data, tab_b[i]);
            pop_a();
        end
        check("a_empty_end", if_a.rx_empty, 1);

        // Waveform of 0xA5 from A, received by B.
        inj_en = 1'b0;
        @(negedge clk);
        if_a.tx_wr_en = 1'b1; if_a.tx_wr_data = 8'hA5;
        @(negedge clk);
        if_a.tx_wr_en = 1'b0;
        lat = 0;
        while (if_a.tx !== 1'b0 && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check("tx_latency_ok", (lat <= 2) ? 1 : 0, 1);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("wave%0d", i), if_a.tx, wave_a5[i]);
            repeat (BIT) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        check("wave_rx_data",  if_b.rx_rd_data, 8'hA5);
        check("wave_rx_empty", if_b.rx_empty, 0);
        pop_b();

        // Error injection sequence.
        inj_en = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1);
        check("perr_data", if_b.rx_rd_data, 8'h3C);
        check("perr_flag", if_b.rx_parity_error, 1);
        check("perr_ferr", if_b.rx_frame_error, 0);
        pop_b();
        send_frame(8'h55, 1'b0, 1'b0);
        check("ferr_data", if_b.rx_rd_data, 8'h55);
        check("ferr_flag", if_b.rx_frame_error, 1);
        check("ferr_perr", if_b.rx_parity_error, 0);
        pop_b();
        send_frame(8'h81, 1'b0, 1'b1);
        check("good_data", if_b.rx_rd_data, 8'h81);
        check("good_errs", {if_b.rx_parity_error, if_b.rx_frame_error}, 0);
        pop_b();
        check("err_empty", if_b.rx_empty, 1);

        // Short low glitch stores nothing; the receiver then takes a good frame.
        inj_val = 1'b0;
        repeat (20) @(negedge clk);
        inj_val = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_empty", if_b.rx_empty, 1);
        send_frame(8'h42, 1'b0, 1'b1);
        check("post_glitch_data",  if_b.rx_rd_data, 8'h42);
        check("post_glitch_empty", if_b.rx_empty, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
